// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the carry-save resolver.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of DIGIT-wide beats needed to cover the WIDTH+1 bit aligned operands.
  function automatic int unsigned beats(input int unsigned width, input int unsigned digit);
    return (width + digit) / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    return $clog2(beats(width, digit) + 1);
  endfunction

endpackage

// File: rtl/digit_add.sv
// DIGIT-bit ripple adder built from full-adder cells.
module digit_add #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/csa_resolver.sv
// Multi-cycle carry-save to binary converter: resolves sum + 2*carry DIGIT bits per cycle.
module csa_resolver
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_value
);

  localparam int unsigned OPW   = WIDTH + 1;
  localparam int unsigned BEATS = beats(WIDTH, DIGIT);
  localparam int unsigned PADW  = BEATS * DIGIT;
  localparam int unsigned CW    = cnt_width(WIDTH, DIGIT);

  state_t          state, state_next;
  logic [PADW-1:0] a, b, res, res_next;
  logic            cy, cy_next;
  logic [CW-1:0]   cnt;
  logic [DIGIT-1:0] d;
  logic            last, load, step;

  digit_add #(.DIGIT(DIGIT)) u_digit_add (
    .a    (a[DIGIT-1:0]),
    .b    (b[DIGIT-1:0]),
    .cin  (cy),
    .sum  (d),
    .cout (cy_next)
  );

  assign last     = (cnt == CW'(BEATS - 1));
  // New digit enters from the MSB side; shift form also covers the single-beat case.
  assign res_next = (res >> DIGIT) | (PADW'(d) << (PADW - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      res       <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      out_value <= '0;
    end else if (load) begin
      a   <= PADW'({1'b0, in_sum});
      b   <= PADW'({in_carry, 1'b0});
      cy  <= 1'b0;
      cnt <= '0;
    end else if (step) begin
      a   <= a >> DIGIT;
      b   <= b >> DIGIT;
      cy  <= cy_next;
      cnt <= cnt + CW'(1);
      res <= res_next;
      // Carry out of bit OPW-1 may land in padding or in the final cy; the truncation picks it up either way.
      if (last) out_value <= (WIDTH + 2)'({cy_next, res_next});
    end
  end

endmodule

// File: doc/csa_resolver.md
# csa_resolver

Multi-cycle converter from carry-save form to plain binary. It accepts one redundant pair per transaction, a sum vector and a carry vector, as produced by the team's carry-save adder stages. It resolves the value sum + 2·carry DIGIT bits per cycle with a ripple digit adder, then presents the binary result on a valid/ready output. It sits at the tail of the CSA reduction tree, where a full-width carry-propagate adder would not meet timing.

## Interface
- WIDTH, 8: width of in_sum and in_carry (≥2).
- DIGIT, 2: bits resolved per cycle (1 ≤ DIGIT ≤ WIDTH+1).
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_sum  input  WIDTH  carry-save sum vector, weight 2^i per bit i.
- in_carry  input  WIDTH  carry-save carry vector, bit i has weight 2^(i+1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_value  output  WIDTH+2  binary value in_sum + 2·in_carry; registered.

## Operation
- Derived constants: OPW = WIDTH+1 (aligned operand width); BEATS = ceil(OPW/DIGIT); operands zero-padded to BEATS·DIGIT bits.
- Load: A = {0, in_sum}, B = {in_carry, 0}, both zero-padded; running carry cy = 0; beat counter = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, load operands and go to RUN.
  - RUN: each cycle, {cy', d} = A[DIGIT-1:0] + B[DIGIT-1:0] + cy. Shift d into the result register from the MSB side. Shift A and B right by DIGIT. Increment counter. After BEATS beats, go to DONE.
  - DONE: out_valid = 1. On out_ready go to IDLE. Otherwise hold out_value unchanged.
- Result: out_value = low OPW bits of the assembled digits, with the final carry as bit WIDTH+1. Padding digits beyond OPW add zero and need no extra handling.
- Width rule: max result 3·(2^WIDTH − 1) < 2^(WIDTH+2), so no overflow is possible and there is no overflow flag.
- Single transaction in flight. in_ready = 0 in RUN and DONE; in_valid in those states is ignored.
- out_value changes only on the RUN→DONE transition. It holds its last result in IDLE and RUN, and is qualified by out_valid.
- Reset mid-operation (RUN or DONE) discards the transaction. No output is produced for it.

## Timing
- Reset values, visible after the first clk edge with rst = 1: state IDLE, in_ready = 1, out_valid = 0, out_value = 0, cy = 0, counter = 0.
- Latency: with the accept at edge k, out_valid is high in the cycle after edge k+BEATS. For WIDTH=8, DIGIT=2: 5 RUN cycles.
- Throughput with out_ready tied high: one result every BEATS+2 cycles (accept, BEATS RUN cycles, DONE).
- out_valid & out_ready in DONE: in_ready returns high the next cycle. No same-cycle accept from DONE.
- rst has priority over every state transition and handshake in the same cycle.
- Critical path: one DIGIT-bit ripple plus counter compare. This is independent of WIDTH.

## Structure
- Package csa_pkg:
  - state enum {IDLE, RUN, DONE};
  - function beats(width, digit) returning ceil((width+1)/digit);
  - counter width constant derived from it.
- Sub-module digit_add: parameterised DIGIT-bit ripple adder built from full-adder cells, with ports a, b, cin, sum, cout. It is instantiated once in the RUN datapath.
- Top level contains the FSM, the operand shift registers, the result shift register and the counter.

## Test plan
All values use WIDTH=8, DIGIT=2.
- Max value: sum=0xFF, carry=0xFF, out_ready=1 → out_value=0x2FD (765), out_valid asserted exactly 5 cycles after the accept cycle.
- Zero and mixed: sum=0x00, carry=0x00 → 0x000. Then sum=0x5A, carry=0x33 → 0x0C0.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE → out_value and out_valid stable, in_ready=0, and an in_valid pulse during that time is not accepted.
- Back-to-back: in_valid held high with operands 0x01/0x01, then 0x80/0x80 → results 0x003, then 0x180, one every 7 cycles.
- Reset mid-RUN: assert rst for 1 cycle after beat 2 → out_valid never rises for that transaction, in_ready=1 and out_value=0 the next cycle. A following transaction sum=0x10, carry=0x08 → 0x020.
- Parameter sweep: DIGIT ∈ {1, 3, 9} with random sum/carry pairs, against the reference model sum+2·carry, with latency equal to beats(8, DIGIT).
